// File: rtl/servant_spi_pkg.sv
// Shared definitions for the servant SPI FRAM slave.
// Holds the MB85RS-style opcodes, the slave FSM state encoding and
// a helper that builds the status register byte.
package servant_spi_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmd    = 3'd1,
    StAddr   = 3'd2,
    StRead   = 3'd3,
    StWrite  = 3'd4,
    StRdsr   = 3'd5,
    StIgnore = 3'd6
  } spi_state_e;

  // Status register as seen by RDSR: only WEL (bit 1) is implemented.
  function automatic logic [7:0] status_byte(input logic wel);
    return {6'b0, wel, 1'b0};
  endfunction

endpackage

// File: rtl/servant_spi_sync.sv
// N-flop synchroniser with a one-cycle edge detector behind it.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_d            : asynchronous input
//   o_level        : synchronised level
//   o_rise/o_fall  : one-cycle pulses on synchronised rising/falling edges
module servant_spi_sync #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/servant_spi_fram_slave.sv
// SPI mode-0 slave emulating a byte-addressed FRAM on top of a byte-wide RAM port.
// All logic runs on wb_clk; SPI pins are oversampled (wb_clk >= 8x SCK).
// Ports:
//   wb_clk, wb_rst_n            : system clock, asynchronous active-low reset
//   spi_sck, spi_ss, spi_mosi   : SPI inputs from the master (ss active low)
//   spi_miso                    : SPI data out, 0 while ss is high
//   ram_addr/ram_wdata/ram_we   : RAM write port (one-cycle strobe)
//   ram_re/ram_rdata            : RAM read strobe, data valid the following cycle
module servant_spi_fram_slave
  import servant_spi_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 24,
  parameter int unsigned MEM_AW        = 18,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [MEM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_rdata
);

  localparam int unsigned AbitW = $clog2(ADDRESS_WIDTH);

  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_ss_lvl, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  servant_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .i_clk(wb_clk), .i_rst_n(wb_rst_n), .i_d(spi_sck),
    .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  // ss idles high, so it resets high to avoid a spurious select after reset.
  servant_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .i_clk(wb_clk), .i_rst_n(wb_rst_n), .i_d(spi_ss),
    .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );
  servant_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk(wb_clk), .i_rst_n(wb_rst_n), .i_d(spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sck_lvl, w_mosi_rise, w_mosi_fall};

  spi_state_e             r_state, w_state_next;
  logic [2:0]             r_bit_cnt;
  logic [AbitW-1:0]       r_abit;
  logic [6:0]             r_rx;
  logic [7:0]             r_tx;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_inc;
  logic [7:0]             r_wdata;
  logic                   r_wel, r_is_write, r_miso, r_we, r_re, r_load, r_wr_inc;
  logic [7:0]             w_rx_next;
  logic                   w_byte_done, w_addr_done;

  assign w_rx_next   = {r_rx, w_mosi};
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_addr_done = (r_abit == AbitW'(ADDRESS_WIDTH - 1));

  // Increment only the RAM-visible bits so the address wraps modulo 2^MEM_AW.
  always_comb begin
    w_addr_inc = r_addr;
    w_addr_inc[MEM_AW-1:0] = r_addr[MEM_AW-1:0] + MEM_AW'(1);
  end

  always_comb begin
    w_state_next = r_state;
    if (w_ss_lvl) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle: if (w_ss_fall) w_state_next = StCmd;
        StCmd: begin
          if (w_sck_rise && w_byte_done) begin
            case (w_rx_next)
              OP_RDSR:           w_state_next = StRdsr;
              OP_READ, OP_WRITE: w_state_next = StAddr;
              default:           w_state_next = StIgnore;
            endcase
          end
        end
        StAddr: if (w_sck_rise && w_addr_done) w_state_next = r_is_write ? StWrite : StRead;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= StIdle;
      r_bit_cnt  <= '0;
      r_abit     <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wel      <= 1'b0;
      r_is_write <= 1'b0;
      r_miso     <= 1'b0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_load     <= 1'b0;
      r_wr_inc   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_wr_inc <= 1'b0;
      r_load   <= r_re;
      // Write address advances the cycle after the strobe so the strobe sees the old address.
      if (r_wr_inc) r_addr <= w_addr_inc;

      if (w_ss_lvl) begin
        r_bit_cnt <= '0;
        r_abit    <= '0;
        r_rx      <= '0;
        r_tx      <= '0;
        r_miso    <= 1'b0;
        if (w_ss_rise && (r_state == StWrite || (r_state == StAddr && r_is_write))) begin
          r_wel <= 1'b0;
        end
      end else begin
        if (w_sck_fall) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
        if (r_load && r_state == StRead) r_tx <= ram_rdata;

        if (w_sck_rise) begin
          r_rx      <= w_rx_next[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          case (r_state)
            StCmd: begin
              if (w_byte_done) begin
                r_abit <= '0;
                case (w_rx_next)
                  OP_WREN:  r_wel <= 1'b1;
                  OP_WRDI:  r_wel <= 1'b0;
                  OP_RDSR:  r_tx <= status_byte(r_wel);
                  OP_READ:  r_is_write <= 1'b0;
                  OP_WRITE: r_is_write <= 1'b1;
                  default:  ;
                endcase
              end
            end
            StAddr: begin
              r_addr <= {r_addr[ADDRESS_WIDTH-2:0], w_mosi};
              r_abit <= r_abit + AbitW'(1);
              if (w_addr_done) r_re <= ~r_is_write;
            end
            StRead: begin
              if (w_byte_done) begin
                r_addr <= w_addr_inc;
                r_re   <= 1'b1;
              end
            end
            StWrite: begin
              if (w_byte_done) begin
                r_we     <= r_wel;
                r_wdata  <= w_rx_next;
                r_wr_inc <= 1'b1;
              end
            end
            StRdsr: if (w_byte_done) r_tx <= status_byte(r_wel);
            default: ;
          endcase
        end
      end
    end
  end

  assign spi_miso  = r_miso;
  assign ram_addr  = r_addr[MEM_AW-1:0];
  assign ram_wdata = r_wdata;
  assign ram_we    = r_we;
  assign ram_re    = r_re;

endmodule

// File: tb/tb_servant_spi_fram_slave.sv
// Bench: SPI master BFM at wb_clk/8 plus a 256 KiB behavioural RAM with 1-cycle read.
module tb_servant_spi_fram_slave;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n, spi_sck, spi_ss, spi_mosi, spi_miso;
  logic [17:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_we, ram_re;

  servant_spi_fram_slave #(.ADDRESS_WIDTH(24), .MEM_AW(18), .SYNC_STAGES(2)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .spi_sck(spi_sck), .spi_ss(spi_ss),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  always #5 wb_clk = ~wb_clk;

  // Behavioural RAM and strobe monitors.
  logic [7:0]  mem [0:262143];
  logic        preload = 1'b0;
  int          we_cnt = 0, re_cnt = 0, overlap = 0;
  logic [17:0] re_log [$];

  always @(posedge wb_clk) begin
    if (preload) begin
      mem[18'h00012] <= 8'h3C;
      mem[18'h00020] <= 8'h77;
      mem[18'h00030] <= 8'h66;
    end
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (ram_re) begin
      ram_rdata <= mem[ram_addr];
      re_cnt <= re_cnt + 1;
      re_log.push_back(ram_addr);
    end
    if (ram_we && ram_re) overlap <= overlap + 1;
  end

  int n_pass = 0, n_checks = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    @(negedge wb_clk) spi_mosi = b;
    repeat (3) @(negedge wb_clk);
    r = spi_miso;  // master samples just before driving the rising edge
    spi_sck = 1'b1;
    repeat (4) @(negedge wb_clk);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic ss_begin();
    @(negedge wb_clk) spi_ss = 1'b0;
    repeat (4) @(negedge wb_clk);
  endtask

  task automatic ss_end();
    repeat (4) @(negedge wb_clk);
    spi_ss = 1'b1;
    repeat (8) @(negedge wb_clk);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    bit          has_addr;
    logic [23:0] addr;
    int          n;
    logic [7:0]  din [3];
    logic [7:0]  dout [3];
    int          we;
    int          re_min;
    int          re_max;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [7:0] cmd, input bit ha,
                              input logic [23:0] a, input int n,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input int we, input int rmin, input int rmax);
    vec_t v;
    v.name = nm; v.cmd = cmd; v.has_addr = ha; v.addr = a; v.n = n;
    v.din[0] = d0; v.din[1] = d1; v.din[2] = d2;
    v.dout[0] = e0; v.dout[1] = e1; v.dout[2] = e2;
    v.we = we; v.re_min = rmin; v.re_max = rmax;
    return v;
  endfunction

  function automatic logic [31:0] re_at(input int idx);
    if (idx < re_log.size()) return 32'(re_log[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic run_row(input vec_t v);
    logic [7:0] rx, e;
    int we0, re0, ri0;
    we0 = we_cnt; re0 = re_cnt; ri0 = re_log.size();
    ss_begin();
    spi_byte(v.cmd, rx);
    if (v.has_addr) begin
      spi_byte(v.addr[23:16], rx);
      spi_byte(v.addr[15:8], rx);
      spi_byte(v.addr[7:0], rx);
    end
    for (int k = 0; k < v.n; k++) begin
      exp_q.push_back(v.dout[k]);
      spi_byte(v.din[k], rx);
      e = exp_q.pop_front();
      chk($sformatf("%s_miso%0d", v.name, k), 32'(rx), 32'(e));
    end
    ss_end();
    chk($sformatf("%s_we_count", v.name), we_cnt - we0, v.we);
    chk_rng($sformatf("%s_re_count", v.name), re_cnt - re0, v.re_min, v.re_max);
    if (v.cmd == 8'h03) begin
      for (int k = 0; k < v.n; k++) begin
        chk($sformatf("%s_re_addr%0d", v.name, k), re_at(ri0 + k),
            (32'(v.addr) + 32'(k)) & 32'h3FFFF);
      end
    end
  endtask

  vec_t vecs [$];

  initial begin
    logic [7:0] rx;
    logic r;
    int we0;

    vecs.push_back(mk("wren1",      8'h06, 0, 24'h0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rdsr_wel",   8'h05, 0, 24'h0,      2, 0, 0, 0, 8'h02, 8'h02, 0, 0, 0, 0));
    vecs.push_back(mk("write10",    8'h02, 1, 24'h000010, 2, 8'hA5, 8'h5A, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk("rdsr_clr",   8'h05, 0, 24'h0,      1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk("write20_nw", 8'h02, 1, 24'h000020, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("read10",     8'h03, 1, 24'h000010, 3, 0, 0, 0, 8'hA5, 8'h5A, 8'h3C, 0, 3, 4));
    vecs.push_back(mk("op9f",       8'h9F, 0, 24'h0,      2, 8'hAA, 8'h55, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wren2",      8'h06, 0, 24'h0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("write_wrap", 8'h02, 1, 24'h03FFFF, 2, 8'h11, 8'h22, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk("read_wrap",  8'h03, 1, 24'h03FFFF, 2, 0, 0, 0, 8'h11, 8'h22, 0, 0, 2, 3));
    vecs.push_back(mk("wren3",      8'h06, 0, 24'h0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wrdi",       8'h04, 0, 24'h0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rdsr_wrdi",  8'h05, 0, 24'h0,      1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));

    wb_rst_n = 1'b0; spi_ss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    @(negedge wb_clk) preload = 1'b1;
    @(negedge wb_clk) preload = 1'b0;
    repeat (3) @(negedge wb_clk);
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_re", 32'(ram_re), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    wb_rst_n = 1'b1;
    repeat (4) @(negedge wb_clk);

    // Reset asserted while RDSR is mid-byte with MISO driving a 1.
    run_row(mk("wren0", 8'h06, 0, 24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    ss_begin();
    spi_byte(8'h05, rx);
    for (int i = 0; i < 6; i++) spi_bit(1'b0, r);
    repeat (4) @(negedge wb_clk);
    chk("pre_reset_miso_wel_bit", 32'(spi_miso), 1);
    wb_rst_n = 1'b0;
    repeat (2) @(negedge wb_clk);
    chk("midreset_miso", 32'(spi_miso), 0);
    chk("midreset_we", 32'(ram_we), 0);
    chk("midreset_re", 32'(ram_re), 0);
    spi_ss = 1'b1;
    repeat (4) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    repeat (4) @(negedge wb_clk);
    run_row(mk("rdsr_after_rst", 8'h05, 0, 24'h0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));

    foreach (vecs[i]) run_row(vecs[i]);

    chk("mem10", 32'(mem[18'h00010]), 32'hA5);
    chk("mem11", 32'(mem[18'h00011]), 32'h5A);
    chk("mem12", 32'(mem[18'h00012]), 32'h3C);
    chk("mem20_unwritten", 32'(mem[18'h00020]), 32'h77);
    chk("mem3ffff", 32'(mem[18'h3FFFF]), 32'h11);
    chk("mem0_wrap", 32'(mem[18'h00000]), 32'h22);

    // ss raised after 5 bits of a WRITE data byte: no strobe, WEL cleared.
    run_row(mk("wren4", 8'h06, 0, 24'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    we0 = we_cnt;
    ss_begin();
    spi_byte(8'h02, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h30, rx);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
    ss_end();
    chk("abort_we_count", we_cnt - we0, 0);
    chk("abort_mem30", 32'(mem[18'h00030]), 32'h66);
    run_row(mk("op9f_after_abort", 8'h9F, 0, 24'h0, 1, 8'hFF, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    run_row(mk("rdsr_after_abort", 8'h05, 0, 24'h0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0));

    chk("we_re_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
